mem_request_unit: RTL and testbench
===================================

MEM_REQUEST_UNIT -- requirements
Module: mem_request_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: max BUS_WAIT cycles before abort.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 nRst  in  1  synchronous active-low reset, sampled on rising clk.
REQ-004 mem_read / mem_write  in  1 each  load / store request from execute stage, held until done.
REQ-005 read_address / write_address  in  32 each  effective load / store address from ALU.
REQ-006 store_data  in  32  store value, right-aligned.
REQ-007 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU illegal for stores.
REQ-008 bus_rdata  in  32  read data from memory bus; bus_busy  in  1  responder busy.
REQ-009 bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}); bus_wdata  out  32  lane-replicated store data.
REQ-010 bus_read / bus_write  out  1 each  strobes; bus_sel  out  4  byte enables.
REQ-011 load_data  out  32  extended load result; done  out  1  one-cycle completion pulse.
REQ-012 stall  out  1  freeze pipeline; error  out  1  one-cycle fault pulse (misaligned, illegal, both requests, timeout).

Function
REQ-013 FSM states IDLE, BUS_REQ, BUS_WAIT, DONE; encoding from shared package.
REQ-014 IDLE: legal request -> BUS_REQ; illegal request -> error=1 for one cycle, done=1 same cycle, no bus strobe, remain IDLE.
REQ-015 Illegal: mem_read&mem_write; H misaligned (addr[0]=1); W misaligned (addr[1:0]!=0); funct3 outside REQ-007 set.
REQ-016 BUS_REQ (exactly one cycle): assert strobe, bus_addr, bus_sel, bus_wdata; bus_busy ignored; -> BUS_WAIT.
REQ-017 BUS_WAIT: strobe, address, sel, wdata held stable; first cycle with bus_busy=0 -> capture load_data (reads) and go DONE.
REQ-018 Timeout counter (8-bit min) counts BUS_WAIT cycles; reaching TIMEOUT with bus_busy=1 -> drop strobes, error pulse, done pulse, -> IDLE; load_data unchanged.
REQ-019 DONE: done=1, strobes low, stall=0 for one cycle; -> IDLE.
REQ-020 stall = (IDLE & (mem_read|mem_write) & legal) | BUS_REQ | BUS_WAIT; combinational.
REQ-021 bus_sel: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
REQ-022 bus_wdata: B = byte replicated x4; H = half replicated x2; W = store_data.
REQ-023 load_data: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through; registered, held until next completed read.
REQ-024 Minimum latency, bus_busy never high: request seen in cycle N -> done in cycle N+3.
REQ-025 Requests that drop while not IDLE are ignored; transaction completes normally.

Reset
REQ-026 nRst=0 at a rising edge -> state IDLE, counter 0, load_data 0, all strobes/done/error/bus_sel 0, bus_addr/bus_wdata 0; applies mid-transaction with no completion pulse.
REQ-027 stall is 0 while nRst=0.

Structure
REQ-028 Shared package holds state enum, funct3 size constants (B/H/W/BU/HU), and TIMEOUT default.
REQ-029 One sub-module, load_extend: combinational lane-select and sign/zero extension (bus_rdata, addr[1:0], funct3 -> 32-bit).

Verification
REQ-030 LW addr 0x100, bus_rdata 0xDEADBEEF, busy never high -> bus_sel 1111, done at N+3, load_data 0xDEADBEEF.
REQ-031 LB addr 0x103, rdata 0x80000000 -> bus_sel 1000, load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SH addr 0x202, store_data 0x1234ABCD -> bus_addr 0x200, bus_sel 1100, bus_wdata 0xABCDABCD, bus_write held over 3 busy cycles, done after busy falls.
REQ-033 LW addr 0x101 -> error+done same cycle, no bus_read ever asserted; mem_read&mem_write -> same.
REQ-034 bus_busy stuck 1 with TIMEOUT=4 -> error+done after 4 BUS_WAIT cycles, strobes low, load_data unchanged.
REQ-035 nRst low during BUS_WAIT -> next cycle all outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/mem_request_unit_pkg.sv
// Shared types and helpers for the load/store bus request unit.
package mem_request_unit_pkg;

  typedef enum logic [1:0] {StIdle, StBusReq, StBusWait, StDone} state_e;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  localparam int unsigned TimeoutDefault = 255;

  function automatic logic [3:0] sel_for(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_for(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic req_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [1:0] lane);
    logic ok;
    case (f3)
      F3Byte:  ok = 1'b1;
      F3ByteU: ok = ~wr;
      F3Half:  ok = ~lane[0];
      F3HalfU: ok = ~wr & ~lane[0];
      F3Word:  ok = (lane == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok & ~(rd & wr);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a bus word and sign- or zero-extends it.
module load_extend
  import mem_request_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3Byte:  data_o = {{24{byte_sel[7]}}, byte_sel};
      F3ByteU: data_o = {24'h000000, byte_sel};
      F3Half:  data_o = {{16{half_sel[15]}}, half_sel};
      F3HalfU: data_o = {16'h0000, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_request_unit.sv
// Turns execute-stage load/store requests into single bus transactions with
// lane steering, load extension, fault detection and a bus-wait timeout.
module mem_request_unit
  import mem_request_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] read_address,
  input  logic [31:0] write_address,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_sel,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall,
  output logic        error
);

  localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic              bus_read_q, bus_read_d;
  logic              bus_write_q, bus_write_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;

  logic              req, req_ok, idle, illegal_now;
  logic [31:0]       req_addr, ext_data;

  assign idle     = (state_q == StIdle);
  assign req      = mem_read | mem_write;
  assign req_addr = mem_read ? read_address : write_address;
  assign req_ok   = req_legal(mem_read, mem_write, funct3, req_addr[1:0]);

  load_extend u_load_extend (
    .rdata_i  (bus_rdata),
    .lane_i   (lane_q),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    load_data_d = load_data_q;
    bus_sel_d   = bus_sel_q;
    bus_read_d  = bus_read_q;
    bus_write_d = bus_write_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && req_ok) begin
          state_d     = StBusReq;
          bus_addr_d  = {req_addr[31:2], 2'b00};
          bus_sel_d   = sel_for(funct3, req_addr[1:0]);
          bus_wdata_d = mem_write ? wdata_for(funct3, store_data) : 32'h0;
          bus_read_d  = mem_read;
          bus_write_d = mem_write;
          f3_d        = funct3;
          lane_d      = req_addr[1:0];
          cnt_d       = '0;
        end
      end
      StBusReq: state_d = StBusWait;
      StBusWait: begin
        if (!bus_busy || cnt_q == CntW'(TIMEOUT - 1)) begin
          // Timeout reuses the DONE cycle (strobes low, no stall) with error added.
          state_d     = StDone;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          bus_sel_d   = 4'h0;
          done_d      = 1'b1;
          err_d       = bus_busy;
          if (!bus_busy && bus_read_q) load_data_d = ext_data;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      load_data_q <= 32'h0;
      bus_sel_q   <= 4'h0;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      f3_q        <= 3'b000;
      lane_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      load_data_q <= load_data_d;
      bus_sel_q   <= bus_sel_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
      done_q      <= done_d;
      err_q       <= err_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
    end
  end

  // Illegal requests are answered in the same cycle, so they never stall.
  assign illegal_now = nRst & idle & req & ~req_ok;
  assign stall = nRst & ((idle & req & req_ok) | (state_q == StBusReq) | (state_q == StBusWait));
  assign done      = done_q | illegal_now;
  assign error     = err_q | illegal_now;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_read  = bus_read_q;
  assign bus_write = bus_write_q;
  assign bus_sel   = bus_sel_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Randomized and directed checks of mem_request_unit against a transaction-level model.
module tb_mem_request_unit;

  localparam int unsigned Tmo = 4;

  logic        clk = 1'b0;
  logic        nRst;
  logic        mem_read, mem_write;
  logic [31:0] read_address, write_address, store_data, bus_rdata;
  logic [2:0]  funct3;
  logic        bus_busy;
  logic [31:0] bus_addr, bus_wdata, load_data;
  logic        bus_read, bus_write, done, stall, error;
  logic [3:0]  bus_sel;

  mem_request_unit #(.TIMEOUT(Tmo)) dut (
    .clk           (clk),
    .nRst          (nRst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .read_address  (read_address),
    .write_address (write_address),
    .store_data    (store_data),
    .funct3        (funct3),
    .bus_rdata     (bus_rdata),
    .bus_busy      (bus_busy),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_read      (bus_read),
    .bus_write     (bus_write),
    .bus_sel       (bus_sel),
    .load_data     (load_data),
    .done          (done),
    .stall         (stall),
    .error         (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_done, exp_err, exp_rd, exp_wr;
  logic [31:0] exp_addr, exp_wdata, exp_load;
  logic [3:0]  exp_sel;
  logic        saw_read;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_sel;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", 32'(stall), 32'(exp_stall));
      cmp("done", 32'(done), 32'(exp_done));
      cmp("error", 32'(error), 32'(exp_err));
      cmp("bus_read", 32'(bus_read), 32'(exp_rd));
      cmp("bus_write", 32'(bus_write), 32'(exp_wr));
      cmp("load_data", load_data, exp_load);
      if (exp_rd || exp_wr) begin
        cmp("bus_addr", bus_addr, exp_addr);
        cmp("bus_sel", 32'(bus_sel), 32'(exp_sel));
        if (exp_wr) cmp("bus_wdata", bus_wdata, exp_wdata);
      end else begin
        cmp("bus_sel_idle", 32'(bus_sel), 32'h0);
      end
    end
    if (bus_read) saw_read = 1'b1;
    if (bus_read || bus_write) begin
      last_addr  = bus_addr;
      last_sel   = bus_sel;
      last_wdata = bus_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_stall = 1'b0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_rd    = 1'b0;
    exp_wr    = 1'b0;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> (8 * int'(lane));
    case (f3)
      3'b000:  return 32'($signed(sh[7:0]));
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return 32'($signed(sh[15:0]));
      3'b101:  return {16'h0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  // One request held until done; busy_pat bit i is bus_busy in bus-wait cycle i.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [2:0] f3, input logic [31:0] sd, input logic [31:0] rdata,
                     input logic [31:0] busy_pat);
    int          size;
    int          lane;
    logic        ok;
    logic        tmo;
    logic [3:0]  sel;
    logic [31:0] wd;
    size = size_of(f3);
    lane = int'(addr[1:0]);
    ok = 1'b1;
    if (size == 0 || (rd && wr) || (wr && f3[2])) ok = 1'b0;
    else if (lane % size != 0) ok = 1'b0;
    sel = 4'h0;
    wd  = 32'h0;
    if (ok) begin
      for (int b = 0; b < 4; b++) begin
        sel[b] = (b >= lane) && (b < lane + size);
        wd[8*b +: 8] = sd[8*(b % size) +: 8];
      end
    end
    mem_read      = rd;
    mem_write     = wr;
    read_address  = rd ? addr : $urandom;
    write_address = wr ? addr : $urandom;
    funct3        = f3;
    store_data    = sd;
    bus_busy      = 1'($urandom);
    bus_rdata     = $urandom;
    if (!ok) begin
      exp_stall = 1'b0;
      exp_done  = 1'b1;
      exp_err   = 1'b1;
      exp_rd    = 1'b0;
      exp_wr    = 1'b0;
      tick();
    end else begin
      exp_stall = 1'b1;
      tick();
      exp_rd    = rd;
      exp_wr    = wr;
      exp_addr  = {addr[31:2], 2'b00};
      exp_sel   = sel;
      exp_wdata = wd;
      bus_busy  = 1'($urandom);
      tick();
      tmo = 1'b1;
      for (int i = 0; i < int'(Tmo); i++) begin
        bus_busy  = busy_pat[i];
        bus_rdata = busy_pat[i] ? $urandom : rdata;
        tick();
        if (!busy_pat[i]) begin
          tmo = 1'b0;
          break;
        end
      end
      exp_stall = 1'b0;
      exp_done  = 1'b1;
      exp_err   = tmo;
      exp_rd    = 1'b0;
      exp_wr    = 1'b0;
      if (rd && !tmo) exp_load = model_load(f3, addr[1:0], rdata);
      bus_busy  = 1'($urandom);
      bus_rdata = $urandom;
      tick();
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    set_idle_exp();
  endtask

  initial begin
    logic        rd, wr;
    logic [31:0] pat;
    nRst = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    read_address = 32'h0;
    write_address = 32'h0;
    store_data = 32'h0;
    funct3 = 3'b000;
    bus_rdata = 32'h0;
    bus_busy = 1'b0;
    saw_read = 1'b0;
    exp_addr = 32'h0;
    exp_wdata = 32'h0;
    exp_sel = 4'h0;
    exp_load = 32'h0;
    set_idle_exp();
    tick();
    tick();
    nRst = 1'b1;
    chk_en = 1'b1;
    tick();

    txn(1'b1, 1'b0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0);
    cmp("lw_data", load_data, 32'hDEADBEEF);
    cmp("lw_sel", 32'(last_sel), 32'hF);
    txn(1'b1, 1'b0, 32'h103, 3'b000, 32'h0, 32'h80000000, 32'h0);
    cmp("lb_data", load_data, 32'hFFFFFF80);
    cmp("lb_sel", 32'(last_sel), 32'h8);
    txn(1'b1, 1'b0, 32'h103, 3'b100, 32'h0, 32'h80000000, 32'h0);
    cmp("lbu_data", load_data, 32'h00000080);
    tick();
    txn(1'b0, 1'b1, 32'h202, 3'b001, 32'h1234ABCD, 32'h0, 32'h7);
    cmp("sh_addr", last_addr, 32'h200);
    cmp("sh_sel", 32'(last_sel), 32'hC);
    cmp("sh_wdata", last_wdata, 32'hABCDABCD);
    saw_read = 1'b0;
    txn(1'b1, 1'b0, 32'h101, 3'b010, 32'h0, 32'h0, 32'h0);
    txn(1'b1, 1'b1, 32'h100, 3'b010, 32'h0, 32'h0, 32'h0);
    tick();
    cmp("illegal_no_read", 32'(saw_read), 32'h0);
    txn(1'b1, 1'b0, 32'h400, 3'b010, 32'h0, 32'h11111111, 32'hFFFFFFFF);
    cmp("tmo_load_kept", load_data, 32'h00000080);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0:       begin rd = 1'b1; wr = 1'b1; end
        1, 2, 3: begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b0; end
      endcase
      pat = $urandom & $urandom;
      if ($urandom_range(0, 7) == 0) pat = 32'hFFFFFFFF;
      txn(rd, wr, $urandom, 3'($urandom), $urandom, $urandom, pat);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    // Reset during bus-wait: everything clears, no completion pulse.
    mem_read = 1'b1;
    read_address = 32'h300;
    funct3 = 3'b010;
    bus_busy = 1'b1;
    exp_stall = 1'b1;
    tick();
    exp_rd = 1'b1;
    exp_addr = 32'h300;
    exp_sel = 4'hF;
    tick();
    tick();
    chk_en = 1'b0;
    nRst = 1'b0;
    mem_read = 1'b0;
    #1;
    cmp("rst_stall", 32'(stall), 32'h0);
    tick();
    nRst = 1'b1;
    set_idle_exp();
    exp_load = 32'h0;
    chk_en = 1'b1;
    #1;
    cmp("rst_addr", bus_addr, 32'h0);
    cmp("rst_wdata", bus_wdata, 32'h0);
    tick();
    tick();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
